// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtract controller:
// FSM state encoding and the default operand width.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/fullsubtractor.sv
// One-bit full subtractor cell: Diff = A - B - Bin, Bout is the borrow out.
module fullsubtractor (
    output logic Bout,
    output logic Diff,
    input  logic A,
    input  logic B,
    input  logic Bin
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule : fullsubtractor

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: time-shares one fullsubtractor cell over WIDTH cycles
// to produce a - b with borrow, zero and signed-overflow flags.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bor;
    logic             r_sticky;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_zero;
    logic             r_ovf;
    logic             w_diff;
    logic             w_bout;
    logic             w_last;

    fullsubtractor u_fs (
        .Bout (w_bout),
        .Diff (w_diff),
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Bin  (r_bor)
    );

    assign w_last = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand shifters, borrow chain, counter and result registers.
    // The minuend shifter doubles as the result shifter: each Diff enters the
    // MSB as the consumed LSB leaves, so after the last bit it holds a - b.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_bor    <= 1'b0;
            r_sticky <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_a      <= a;
            r_b      <= b;
            r_cnt    <= '0;
            r_bor    <= 1'b0;
            r_sticky <= 1'b0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
        end else if (r_state == ST_RUN) begin
            r_a      <= {w_diff, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_bor    <= w_bout;
            r_sticky <= r_sticky | w_diff;
            if (w_last) begin
                r_diff   <= {w_diff, r_a[WIDTH-1:1]};
                r_borrow <= w_bout;
                r_zero   <= ~(r_sticky | w_diff);
                r_ovf    <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_diff);
            end else begin
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt    <= r_cnt;
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign zero   = r_zero;
    assign ovf    = r_ovf;

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=32 with hand-computed results.
module tb_serial_sub_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;

    int vec_cnt = 0;
    int err_cnt = 0;

    serial_sub_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation from an idle controller; optional ignored start in intr_cyc.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input int intr_cyc, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] e_diff, input logic e_bor, input logic e_zero,
                          input logic e_ovf);
        int          ndone;
        int          done_cyc;
        int          busy_err;
        logic [31:0] s_diff;
        logic        s_bor;
        logic        s_zero;
        logic        s_ovf;
        ndone = 0; done_cyc = 0; busy_err = 0;
        s_diff = '0; s_bor = 1'b0; s_zero = 1'b0; s_ovf = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = ta; b = tb_v;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hFFFF_FFFF; b = 32'h0000_0000;
        for (int c = 1; c <= 33; c++) begin
            if (c == intr_cyc) begin
                start = 1'b1; a = ia; b = ib;
            end
            @(negedge clk);
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            if (!busy) busy_err++;
            if (c == 33) begin
                s_diff = diff; s_bor = borrow; s_zero = zero; s_ovf = ovf;
            end
            @(posedge clk); #1;
            if (c == intr_cyc) start = 1'b0;
        end
        check_val({tag, ".done_cnt"}, 64'(ndone), 64'd1);
        check_val({tag, ".done_cyc"}, 64'(done_cyc), 64'd33);
        check_val({tag, ".busy_run"}, 64'(busy_err), 64'd0);
        check_val({tag, ".diff"}, 64'(s_diff), 64'(e_diff));
        check_val({tag, ".borrow"}, 64'(s_bor), 64'(e_bor));
        check_val({tag, ".zero"}, 64'(s_zero), 64'(e_zero));
        check_val({tag, ".ovf"}, 64'(s_ovf), 64'(e_ovf));
        @(negedge clk);
        check_val({tag, ".busy34"}, 64'(busy), 64'd0);
        check_val({tag, ".hold34"}, 64'(diff), 64'(e_diff));
    endtask

    initial begin
        int ndone;
        int bad_busy;
        int bad_done;
        int bad_out;
        int bad_hold;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst.busy", 64'(busy), 64'd0);
        check_val("rst.done", 64'(done), 64'd0);
        check_val("rst.flags", 64'({diff, borrow, zero, ovf}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("sub5_3", 32'd5, 32'd3, 0, '0, '0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_op("sub3_5", 32'd3, 32'd5, 0, '0, '0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        run_op("equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, '0, '0, 32'h0, 1'b0, 1'b1, 1'b0);
        run_op("ovf_neg", 32'h8000_0000, 32'h1, 0, '0, '0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, '0, '0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        run_op("ignore", 32'd9, 32'd4, 10, 32'd1, 32'd1, 32'd5, 1'b0, 1'b0, 1'b0);

        // Reset in cycle 10 of an operation: no done, outputs cleared from cycle 11.
        @(posedge clk); #1;
        start = 1'b1; a = 32'd9; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; bad_busy = 0; bad_out = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) rst = 1'b1;
            @(negedge clk);
            if (done) ndone++;
            if (c >= 11) begin
                if (busy) bad_busy++;
                if ({diff, borrow, zero, ovf} != 35'd0) bad_out++;
            end
            @(posedge clk); #1;
            if (c == 10) rst = 1'b0;
        end
        check_val("rstmid.done", 64'(ndone), 64'd0);
        check_val("rstmid.busy", 64'(bad_busy), 64'd0);
        check_val("rstmid.outs", 64'(bad_out), 64'd0);
        run_op("fresh", 32'd100, 32'd58, 0, '0, '0, 32'h0000_002A, 1'b0, 1'b0, 1'b0);

        // start held high: done in 33, 67, 101; idle only in 34 and 68.
        @(posedge clk); #1;
        start = 1'b1; a = 32'd10; b = 32'd1;
        @(posedge clk); #1;
        ndone = 0; bad_busy = 0; bad_done = 0; bad_hold = 0;
        for (int c = 1; c <= 101; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (done != ((c == 33) || (c == 67) || (c == 101))) bad_done++;
            if (busy != !((c == 34) || (c == 68))) bad_busy++;
            if ((c >= 33) && (diff != 32'd9)) bad_hold++;
            @(posedge clk); #1;
            if (c == 100) start = 1'b0;
        end
        check_val("hold.done_cnt", 64'(ndone), 64'd3);
        check_val("hold.done_cyc", 64'(bad_done), 64'd0);
        check_val("hold.busy", 64'(bad_busy), 64'd0);
        check_val("hold.diff", 64'(bad_hold), 64'd0);
        @(negedge clk);
        check_val("hold.idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_serial_sub_ctrl
